sseg_scan_ctrl: RTL and testbench

- Time-multiplexes NUM_DIGITS hex digits onto one shared seven-segment decoder and a common-anode display.
- Each scan slot steps through the digits, presents a nibble on num to the external decoder, and drives the active-low digit anodes and decimal point.
- Provides an anti-ghosting blank interval, leading-zero blanking, and a frame-synchronous shadow load so the displayed value never tears mid-frame.

---
 rtl/sseg_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with blank interval, leading-zero blanking and frame-synchronous shadow load.
// Optional macro SSEG_PWM_EN adds a 4-bit brightness input that gates the anode/dp during DRIVE.
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank_en,
`ifdef SSEG_PWM_EN
    input  logic [3:0]              bright,
`endif
    output logic [3:0]              num,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic                    frame_start,
    output logic                    load_ack
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(TICK_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t                  state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic                    new_frame_reg;
    logic                    xfer_done_reg;

    logic [4*NUM_DIGITS-1:0] pend_value_reg;
    logic [NUM_DIGITS-1:0]   pend_dp_reg;
    logic                    pend_valid_reg;
    logic [4*NUM_DIGITS-1:0] act_value_reg;
    logic [NUM_DIGITS-1:0]   act_dp_reg;

    logic                    slot_end;
    logic                    boundary;
    logic                    xfer;
    logic                    pwm_on;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   an_next;

    logic [3:0]              nibbles [NUM_DIGITS];
    logic [NUM_DIGITS:1]     zero_from;
    logic [NUM_DIGITS-1:0]   digit_blank;

    assign slot_end = (state_reg == DRIVE) && (cnt_reg == DRIVE_LAST);
    assign boundary = slot_end && (idx_reg == IDX_LAST);
    assign xfer     = boundary && pend_valid_reg;

    // zero_from[i] is set when every active nibble from i upward is zero.
    assign zero_from[NUM_DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nibbles[gi] = act_value_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign digit_blank[gi] = 1'b0;
            end else begin : g_upper
                assign zero_from[gi]   = zero_from[gi+1] && (nibbles[gi] == 4'h0);
                assign digit_blank[gi] = lz_blank_en && zero_from[gi];
            end
        end
    endgenerate

`ifdef SSEG_PWM_EN
    logic [3:0] pwm_cnt_reg;

    // Restart the duty window on the first DRIVE cycle of every slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_reg <= 4'h0;
        end else if (state_reg == BLANK && cnt_reg == BLANK_LAST) begin
            pwm_cnt_reg <= 4'h0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 4'h1;
        end
    end

    assign pwm_on = (pwm_cnt_reg <= bright);
`else
    assign pwm_on = 1'b1;
`endif

    assign lit = (state_reg == DRIVE) && !digit_blank[idx_reg] && pwm_on;

    always_comb begin
        an_next = '1;
        if (lit) begin
            an_next[idx_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BLANK;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            new_frame_reg <= 1'b0;
            xfer_done_reg <= 1'b0;
            an            <= '1;
            dp            <= 1'b1;
            num           <= 4'h0;
            frame_start   <= 1'b0;
            load_ack      <= 1'b0;
        end else begin
            an            <= an_next;
            dp            <= lit ? ~act_dp_reg[idx_reg] : 1'b1;
            num           <= nibbles[idx_reg];
            frame_start   <= new_frame_reg;
            load_ack      <= xfer_done_reg;
            new_frame_reg <= boundary;
            xfer_done_reg <= xfer;
            case (state_reg)
                BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_reg <= DRIVE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DRIVE: begin
                    if (slot_end) begin
                        state_reg <= BLANK;
                        cnt_reg   <= '0;
                        idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= BLANK;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // A load coinciding with the boundary is held in pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_valid_reg <= 1'b0;
            act_value_reg  <= '0;
            act_dp_reg     <= '0;
        end else begin
            if (xfer) begin
                act_value_reg <= pend_value_reg;
                act_dp_reg    <= pend_dp_reg;
            end
            if (load) begin
                pend_value_reg <= value;
                pend_dp_reg    <= dp_mask;
                pend_valid_reg <= 1'b1;
            end else if (xfer) begin
                pend_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Scoreboard bench for sseg_scan_ctrl: stimulus queues one expected record per frame, a monitor checks each frame cycle by cycle.
module tb_sseg_scan_ctrl;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  lit;
        logic [3:0]  dpl;
        logic        fs;
        logic        ack;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;
    logic        lz_blank_en = 1'b0;
    logic [3:0]  num;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;
    logic        load_ack;

    int     checks = 0;
    int     failures = 0;
    bit     mon_en = 1'b1;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    sseg_scan_ctrl #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_mask    (dp_mask),
        .lz_blank_en(lz_blank_en),
`ifdef SSEG_PWM_EN
        .bright     (4'hF),
`endif
        .num        (num),
        .an         (an),
        .dp         (dp),
        .frame_start(frame_start),
        .load_ack   (load_ack)
    );

    task automatic push_frame(input logic [15:0] v, input logic [3:0] lit, input logic [3:0] dpl,
                              input logic fs, input logic ack);
        frame_t f;
        f.val = v; f.lit = lit; f.dpl = dpl; f.fs = fs; f.ack = ack;
        exp_q.push_back(f);
    endtask

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 100);
        if (!frame_start) begin
            checks++; failures++;
            $display("FAIL frame_timeout: no frame_start within %0d cycles, required one", n);
            finish_tb();
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        value = v; dp_mask = m; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Monitor: a frame begins on frame_start or on the first sample after reset release.
    initial begin
        frame_t      e;
        bit          prev_rst = 1'b0;
        bit          begin_f;
        bit          bad;
        int          d, ph;
        logic [3:0]  exp_an;
        logic        exp_dp;
        logic [3:0]  exp_num;
        forever begin
            @(negedge clk);
            begin_f  = mon_en && rst_n && (frame_start || !prev_rst);
            prev_rst = rst_n;
            if (begin_f) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL frame_unexpected: frame began with fs=%0b but none was queued", frame_start);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({frame_start, load_ack} !== {e.fs, e.ack}) begin
                        failures++;
                        $display("FAIL frame_pulses: frame_start=%0b load_ack=%0b, required %0b %0b",
                                 frame_start, load_ack, e.fs, e.ack);
                    end
                    bad = 1'b0;
                    for (int c = 0; c < 32; c++) begin
                        if (c > 0) begin
                            @(negedge clk);
                            prev_rst = rst_n;
                            if (!mon_en) break;
                        end
                        d  = c / 8;
                        ph = c % 8;
                        exp_num = e.val[4*d +: 4];
                        exp_an  = 4'b1111;
                        exp_dp  = 1'b1;
                        if (ph >= 2 && e.lit[d]) begin
                            exp_an[d] = 1'b0;
                            exp_dp    = ~e.dpl[d];
                        end
                        if (an !== exp_an || dp !== exp_dp || num !== exp_num ||
                            (c > 0 && (frame_start !== 1'b0 || load_ack !== 1'b0))) begin
                            if (!bad) begin
                                $display("FAIL slot%0d cycle%0d: an=%b dp=%b num=%h fs=%b ack=%b, required an=%b dp=%b num=%h",
                                         d, c, an, dp, num, frame_start, load_ack, exp_an, exp_dp, exp_num);
                            end
                            bad = 1'b1;
                        end
                        if (ph == 7) begin
                            checks++;
                            if (bad) failures++;
                            bad = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        wait_cyc(3);
        checks++;
        if (an !== 4'b1111 || dp !== 1'b1 || num !== 4'h0 || frame_start !== 1'b0 || load_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: an=%b dp=%b num=%h fs=%b ack=%b, required 1111 1 0 0 0",
                     an, dp, num, frame_start, load_ack);
        end
        push_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        push_frame(16'h0000, 4'b1111, 4'b0000, 1'b1, 1'b0);
        #1 rst_n = 1'b1;

        n = 0;
        do begin
            @(negedge clk);
            if (!frame_start) n++;
        end while (!frame_start && n < 100);
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL first_frame_start: came after %0d cycles, required 32", n);
            if (!frame_start) finish_tb();
        end

        wait_cyc(10);
        do_load(16'h12AF, 4'b0100);
        push_frame(16'h12AF, 4'b1111, 4'b0100, 1'b1, 1'b1);
        wait_frame();

        wait_cyc(10);
        do_load(16'h0005, 4'b0000);
        push_frame(16'h0005, 4'b0001, 4'b0000, 1'b1, 1'b1);
        wait_frame();
        lz_blank_en = 1'b1;

        wait_cyc(10);
        do_load(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b1);
        wait_frame();

        wait_cyc(5);
        do_load(16'h1111, 4'b0000);
        wait_cyc(5);
        do_load(16'h2222, 4'b0000);
        push_frame(16'h2222, 4'b1111, 4'b0000, 1'b1, 1'b1);
        wait_frame();
        lz_blank_en = 1'b0;

        // Second load is sampled on the boundary edge itself.
        wait_cyc(10);
        do_load(16'h4444, 4'b0000);
        push_frame(16'h4444, 4'b1111, 4'b0000, 1'b1, 1'b1);
        wait_cyc(19);
        do_load(16'h3333, 4'b0000);
        push_frame(16'h3333, 4'b1111, 4'b0000, 1'b1, 1'b1);
        push_frame(16'h3333, 4'b1111, 4'b0000, 1'b1, 1'b0);
        wait_frame();
        wait_frame();
        wait_frame();

        wait_cyc(19);
        mon_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111 || dp !== 1'b1 || num !== 4'h0 || frame_start !== 1'b0 || load_ack !== 1'b0) begin
            failures++;
            $display("FAIL midslot_reset: an=%b dp=%b num=%h fs=%b ack=%b, required 1111 1 0 0 0",
                     an, dp, num, frame_start, load_ack);
        end
        push_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0);
        push_frame(16'h0000, 4'b1111, 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        mon_en = 1'b1;
        #1 rst_n = 1'b1;
        wait_frame();
        wait_cyc(31);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: %0d frames still expected, required 0", exp_q.size());
        end
        finish_tb();
    end

endmodule
